spi_debug_ctrl: RTL
===================

Name: spi_debug_ctrl

Overview:
Debug command controller sitting directly downstream of SPI_Slave_Parallel and upstream of the instruction Single_port_ram. It decodes each 32-bit word delivered by the SPI slave and accumulates half-word data and an address. It issues single-cycle write and read strobes to the RAM and registers the readback word returned to the SPI slave's i_data input.

Parameters:
NB_BITS, 32, data/command word width (fixed 32 for field layout)
RAM_DEPTH, 10, RAM address width

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous, active-low reset
i_cmd  in  NB_BITS  command word from SPI slave o_data
i_cmd_valid  in  1  one-cycle strobe: new i_cmd word available
i_mem_rdata  in  NB_BITS  RAM o_data
i_pc  in  NB_BITS  current PC
i_pc_latched  in  NB_BITS  IF/ID latched PC
i_instr_latched  in  NB_BITS  IF/ID latched instruction
o_mem_addr  out  RAM_DEPTH  RAM address
o_mem_wdata  out  NB_BITS  RAM write data
o_mem_we  out  1  RAM write enable, one-cycle pulse
o_rdback  out  NB_BITS  word to SPI slave i_data
o_busy  out  1  high while FSM not IDLE
o_err  out  1  sticky protocol error flag

Behaviour:
- Command fields: [31] write, [30] read, [29:28] op (00 mem, 01 HL_DATA, 10 HU_DATA, 11 ADDRESS), [26:25] readback select (00 PC, 01 PC_LATCHED, 10 INSTR_LATCHED, 11 MEM_DATA), [15:0] payload. [27] and [24:16] are ignored.
- Reset (i_rst=0, async): all outputs 0, FSM to IDLE, all internal registers 0. A reset mid-operation aborts any pending strobe; no partial write occurs after reset release.
- Commands are accepted only in IDLE on i_cmd_valid=1. Effects apply on the same edge:
  - op 01: o_mem_wdata[15:0] <= payload.
  - op 10: o_mem_wdata[31:16] <= payload.
  - op 11: o_mem_addr <= payload[RAM_DEPTH-1:0].
  - op 00, [31]=1: go to WRITE. o_mem_we=1 for exactly the next cycle, then IDLE.
  - op 00, [30]=1, [31]=0: go to READ. The RAM has 1-cycle synchronous read, so the next cycle is RD_CAP, where i_mem_rdata is captured into mem_data_q, then IDLE.
  - op 00 with [31]=[30]=1: write wins, read is dropped, o_err set.
  - op 00 with [31]=[30]=0: no operation.
- Readback select is latched on every accepted command. o_rdback is registered: selected source is sampled each cycle; MEM_DATA returns mem_data_q.
- States: IDLE -> WRITE -> IDLE; IDLE -> READ -> RD_CAP -> IDLE. o_busy = (state != IDLE).
- i_cmd_valid while busy: the command is ignored entirely (no field update) and o_err is set. o_err clears only on reset.
- o_mem_addr and o_mem_wdata hold their values between commands. Address arithmetic wraps modulo 2^RAM_DEPTH.

Optional Feature:
ADDR_AUTOINC_EN: when defined, the cycle after a completed WRITE (WRITE -> IDLE) or RD_CAP increments o_mem_addr by 1, wrapping from 2^RAM_DEPTH-1 to 0. This allows burst loading with no ADDRESS command between words. An ADDRESS command arriving afterwards overrides the incremented value. When undefined, o_mem_addr changes only on ADDRESS commands.

Decomposition:
- Shared package dbg_pkg holds:
  - field bit-position constants (CMD_WR_BIT=31, CMD_RD_BIT=30, CMD_OP_MSB/LSB, CMD_SEL_MSB/LSB)
  - op codes (OP_MEM, OP_HL, OP_HU, OP_ADDR)
  - readback select codes
  - FSM state encodings
- One sub-module, dbg_rdback_mux: registered 4:1 readback selector.

Test Plan:
1. Reset held low, then released -> o_mem_addr=0, o_mem_wdata=0, o_mem_we=0, o_rdback=0, o_busy=0, o_err=0.
2. Valid 0x1000FFFF, 0x2000F0F0, 0x30000005, 0x80000000 -> wdata=0xF0F0FFFF, addr=5, o_mem_we high exactly one cycle, the cycle after the 4th valid.
3. Preload RAM[5]=0xDEADBEEF; issue read 0x46000000 (read, sel=11) -> o_busy high 2 cycles; o_rdback=0xDEADBEEF from the cycle after RD_CAP.
4. Sel=00 with i_pc=0x40, then sel=01 with i_pc_latched=0x3C -> o_rdback=0x40, then 0x3C, one cycle after each valid.
5. Valid 0xC0000000 (write and read) -> single write pulse, no read, o_err=1. Then a second valid during WRITE -> ignored, wdata unchanged.
6. With ADDR_AUTOINC_EN and addr=0x3FF, write -> o_mem_addr=0x000 after completion. Without the macro -> addr remains 0x3FF. Reset asserted during WRITE -> o_mem_we=0 immediately.

Source files
------------

// File: rtl/dbg_pkg.sv
// -----------------------------------------------------------------------------
// dbg_pkg
// Shared definitions for the SPI debug command controller:
//   - bit positions of the fields inside a 32-bit command word
//   - op codes, readback select codes, FSM state encodings
// Optional feature macro used by the controller: ADDR_AUTOINC_EN
// -----------------------------------------------------------------------------
package dbg_pkg;

   // Command word field positions
   localparam int CMD_WR_BIT  = 31;
   localparam int CMD_RD_BIT  = 30;
   localparam int CMD_OP_MSB  = 29;
   localparam int CMD_OP_LSB  = 28;
   localparam int CMD_SEL_MSB = 26;
   localparam int CMD_SEL_LSB = 25;
   localparam int CMD_PAY_MSB = 15;
   localparam int CMD_PAY_LSB = 0;

   typedef enum logic [1:0] {
      OP_MEM  = 2'b00,
      OP_HL   = 2'b01,
      OP_HU   = 2'b10,
      OP_ADDR = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      SEL_PC            = 2'b00,
      SEL_PC_LATCHED    = 2'b01,
      SEL_INSTR_LATCHED = 2'b10,
      SEL_MEM_DATA      = 2'b11
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_WRITE  = 2'b01,
      ST_READ   = 2'b10,
      ST_RD_CAP = 2'b11
   } state_e;

endpackage

// File: rtl/dbg_rdback_mux.sv
// -----------------------------------------------------------------------------
// dbg_rdback_mux
// Registered 4:1 selector producing the readback word for the SPI slave.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   sel_i                 source select (sel_e)
//   pc_i                  current PC
//   pc_latched_i          IF/ID latched PC
//   instr_latched_i       IF/ID latched instruction
//   mem_data_i            captured RAM readback word
//   rdback_o              registered selected word
// -----------------------------------------------------------------------------
module dbg_rdback_mux
   import dbg_pkg::*;
#(
   parameter int NB_BITS = 32
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  sel_e               sel_i,
   input  logic [NB_BITS-1:0] pc_i,
   input  logic [NB_BITS-1:0] pc_latched_i,
   input  logic [NB_BITS-1:0] instr_latched_i,
   input  logic [NB_BITS-1:0] mem_data_i,
   output logic [NB_BITS-1:0] rdback_o
);

   logic [NB_BITS-1:0] rdback_d;
   logic [NB_BITS-1:0] rdback_q;

   always_comb begin
      rdback_d = pc_i;
      unique case (sel_i)
         SEL_PC:            rdback_d = pc_i;
         SEL_PC_LATCHED:    rdback_d = pc_latched_i;
         SEL_INSTR_LATCHED: rdback_d = instr_latched_i;
         SEL_MEM_DATA:      rdback_d = mem_data_i;
         default:           rdback_d = pc_i;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdback_q <= '0;
      end else begin
         rdback_q <= rdback_d;
      end
   end

   assign rdback_o = rdback_q;

endmodule

// File: rtl/spi_debug_ctrl.sv
// -----------------------------------------------------------------------------
// spi_debug_ctrl
// Decodes 32-bit debug commands from the SPI slave, accumulates write data and
// an address, pulses RAM write strobes, sequences RAM reads and returns a
// registered readback word.
// Optional feature: define ADDR_AUTOINC_EN to post-increment the RAM address
// after every completed write or read (burst access without ADDRESS commands).
// Ports:
//   i_clk, i_rst          clock, asynchronous active-low reset
//   i_cmd, i_cmd_valid    command word and its one-cycle strobe
//   i_mem_rdata           RAM read data (1-cycle synchronous read)
//   i_pc, i_pc_latched,
//   i_instr_latched       readback sources from the core
//   o_mem_addr            RAM address
//   o_mem_wdata           RAM write data
//   o_mem_we              RAM write enable, one-cycle pulse
//   o_rdback              readback word to the SPI slave
//   o_busy                high while the FSM is not idle
//   o_err                 sticky protocol error
// -----------------------------------------------------------------------------
module spi_debug_ctrl
   import dbg_pkg::*;
#(
   parameter int NB_BITS   = 32,
   parameter int RAM_DEPTH = 10
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [NB_BITS-1:0]   i_cmd,
   input  logic                 i_cmd_valid,
   input  logic [NB_BITS-1:0]   i_mem_rdata,
   input  logic [NB_BITS-1:0]   i_pc,
   input  logic [NB_BITS-1:0]   i_pc_latched,
   input  logic [NB_BITS-1:0]   i_instr_latched,
   output logic [RAM_DEPTH-1:0] o_mem_addr,
   output logic [NB_BITS-1:0]   o_mem_wdata,
   output logic                 o_mem_we,
   output logic [NB_BITS-1:0]   o_rdback,
   output logic                 o_busy,
   output logic                 o_err
);

   state_e               state_q;
   logic [RAM_DEPTH-1:0] addr_q;
   logic [NB_BITS-1:0]   wdata_q;
   logic                 we_q;
   logic                 err_q;
   sel_e                 sel_q;
   sel_e                 sel_d;
   logic [NB_BITS-1:0]   mem_data_q;
   logic [NB_BITS-1:0]   mem_data_d;

   logic                 cmd_acc;
   logic                 cmd_wr;
   logic                 cmd_rd;
   op_e                  cmd_op;
   logic [15:0]          cmd_payload;
   logic                 unused_cmd_bits;

   assign cmd_acc     = i_cmd_valid && (state_q == ST_IDLE);
   assign cmd_wr      = i_cmd[CMD_WR_BIT];
   assign cmd_rd      = i_cmd[CMD_RD_BIT];
   assign cmd_op      = op_e'(i_cmd[CMD_OP_MSB:CMD_OP_LSB]);
   assign cmd_payload = i_cmd[CMD_PAY_MSB:CMD_PAY_LSB];
   assign unused_cmd_bits = ^{i_cmd[27], i_cmd[24:16]};

   // The readback register is fed with the next-state select and captured
   // memory word so o_rdback reflects a new command (or a finished read) one
   // cycle after it happens instead of two.
   assign sel_d      = cmd_acc ? sel_e'(i_cmd[CMD_SEL_MSB:CMD_SEL_LSB]) : sel_q;
   assign mem_data_d = (state_q == ST_RD_CAP) ? i_mem_rdata : mem_data_q;

`ifdef ADDR_AUTOINC_EN
   localparam logic [RAM_DEPTH-1:0] ADDR_ONE = 1;
`endif

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         sel_q      <= SEL_PC;
         mem_data_q <= '0;
      end else begin
         we_q       <= 1'b0;
         sel_q      <= sel_d;
         mem_data_q <= mem_data_d;

         // Commands arriving while busy are dropped and flagged.
         if (i_cmd_valid && (state_q != ST_IDLE)) begin
            err_q <= 1'b1;
         end

         unique case (state_q)
            ST_IDLE: begin
               if (i_cmd_valid) begin
                  unique case (cmd_op)
                     OP_HL:   wdata_q[15:0]  <= cmd_payload;
                     OP_HU:   wdata_q[31:16] <= cmd_payload;
                     OP_ADDR: addr_q         <= cmd_payload[RAM_DEPTH-1:0];
                     OP_MEM: begin
                        if (cmd_wr) begin
                           // Write has priority; a simultaneous read is an error.
                           state_q <= ST_WRITE;
                           we_q    <= 1'b1;
                           if (cmd_rd) begin
                              err_q <= 1'b1;
                           end
                        end else if (cmd_rd) begin
                           state_q <= ST_READ;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            ST_WRITE: begin
               state_q <= ST_IDLE;
`ifdef ADDR_AUTOINC_EN
               addr_q  <= addr_q + ADDR_ONE;
`endif
            end
            ST_READ: begin
               // RAM registers its output on this edge; data is taken next cycle.
               state_q <= ST_RD_CAP;
            end
            ST_RD_CAP: begin
               state_q <= ST_IDLE;
`ifdef ADDR_AUTOINC_EN
               addr_q  <= addr_q + ADDR_ONE;
`endif
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   dbg_rdback_mux #(
      .NB_BITS (NB_BITS)
   ) u_rdback_mux (
      .clk_i           (i_clk),
      .rst_ni          (i_rst),
      .sel_i           (sel_d),
      .pc_i            (i_pc),
      .pc_latched_i    (i_pc_latched),
      .instr_latched_i (i_instr_latched),
      .mem_data_i      (mem_data_d),
      .rdback_o        (o_rdback)
   );

   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_we    = we_q;
   assign o_busy      = (state_q != ST_IDLE);
   assign o_err       = err_q;

endmodule
